digit_serial_adder_ctrl: RTL and testbench

- Sequences one narrow DIGIT-bit ripple-carry adder slice over WIDTH-bit operands, one slice per clock, LSB slice first.
- The carry is registered between slices, so wide additions run on a small adder at the cost of WIDTH/DIGIT cycles.
- Valid/ready handshake on input and output; sits between an operand source and a result consumer in the arithmetic datapath.
- Also supports subtraction (a - b) and reports carry-out and signed overflow.

---
 rtl/digit_serial_adder_ctrl.sv | 125 ++++++++++++
 tb/tb_digit_serial_adder_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder_ctrl.sv
// rtl/digit_serial_adder_ctrl.sv - digit-serial add/subtract sequencer over a DIGIT-bit ripple-carry slice
module digit_serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT-1:0] sa, sb, ss;
  logic [DIGIT:0]   rc;

  // One DIGIT-bit ripple-carry slice, fed from the registered carry.
  always_comb begin
    sa    = a_q[cnt_q*DIGIT +: DIGIT];
    sb    = b_q[cnt_q*DIGIT +: DIGIT];
    rc    = '0;
    ss    = '0;
    rc[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      ss[i]   = sa[i] ^ sb[i] ^ rc[i];
      rc[i+1] = (sa[i] & sb[i]) | (rc[i] & (sa[i] ^ sb[i]));
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*DIGIT +: DIGIT] = ss;
        carry_d = rc[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = rc[DIGIT];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ss[DIGIT-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // out_valid registers one cycle into DONE; the result is only consumed once it is visible.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// tb/tb_digit_serial_adder_ctrl.sv - randomized self-checking bench against an arithmetic reference model
module tb_digit_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  digit_serial_adder_ctrl #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow judged by range.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                                input logic ms, output logic [15:0] es, output logic ec,
                                output logic eo);
    int unsigned full;
    int          r;
    if (ms) begin
      es = ma - mb;
      ec = (ma >= mb);
      r  = int'($signed(ma)) - int'($signed(mb));
    end else begin
      full = 32'(ma) + 32'(mb) + 32'(mc);
      es   = full[15:0];
      ec   = (full > 32'd65535);
      r    = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    end
    eo = (r > 32767) || (r < -32768);
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic ts, input int stall, input bit toggle);
    logic [15:0] es;
    logic        ec, eo;
    int          n;
    model(ta, tb, tc, ts, es, ec, eo);
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1'b1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
      if (toggle) begin
        check_eq("in_ready_run", in_ready, 1'b0);
        check_eq("busy_run", busy, 1'b1);
        in_valid = ~in_valid;
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    check_eq("latency", n, 5);
    check_eq("sum", sum, es);
    check_eq("cout", cout, ec);
    check_eq("ovf", ovf, eo);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_sum", sum, es);
      check_eq("hold_in_ready", in_ready, 1'b0);
      if (toggle) begin
        in_valid = ~in_valid;
        a = 16'($urandom);
      end
    end
    if (stall > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("valid_drop", out_valid, 1'b0);
    check_eq("back_idle", in_ready, 1'b1);
    check_eq("keep_sum", sum, es);
  endtask

  initial begin
    logic [15:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_sum", sum, 16'h0);
    check_eq("rst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    check_eq("dir_5555", sum, 16'h5555);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    check_eq("dir_carry_all", cout, 1'b1);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    check_eq("dir_ovf_add", ovf, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
    check_eq("dir_sub_neg", sum, 16'hFFFE);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    check_eq("dir_ovf_sub", ovf, 1'b1);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3, 1'b1);
    do_op(16'hA5A5, 16'h0F0F, 1'b0, 1'b1, 0, 1'b0);

    // Abort mid-RUN after slices 0 and 1 have been written.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_valid", out_valid, 1'b0);
    check_eq("abort_sum", sum, 16'h0);
    check_eq("abort_cout", cout, 1'b0);
    check_eq("abort_ovf", ovf, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 8 == 0) rb = ~ra;
      if (k % 8 == 1) rb = ra;
      do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
